// File: rtl/score_arbiter.sv
// Per-source scoring events are accumulated into saturating pending counters and
// drained one point at a time, round-robin, as paced single-point score pulses.

module score_arbiter_lane #(
  parameter int PEND_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hit,
  input  logic              enable,
  input  logic              clear,
  input  logic [7:0]        points,
  input  logic              dec,
  output logic [PEND_W-1:0] pending,
  output logic              sat
);
  localparam int SW = PEND_W + 9;
  localparam logic [SW-1:0] MAXV = SW'((1 << PEND_W) - 1);

  logic          hit_q, armed, rise;
  logic [SW-1:0] sum;

  // armed masks the first clock after reset so a hit held high across release is not an event
  assign rise = hit & ~hit_q & armed & enable;
  assign sum  = SW'(pending) + (rise ? SW'(points) : '0) - SW'(dec);
  assign sat  = ~clear & (sum > MAXV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= 1'b0;
      armed   <= 1'b0;
      pending <= '0;
    end else begin
      hit_q <= hit;
      armed <= 1'b1;
      if (clear)           pending <= '0;
      else if (sum > MAXV) pending <= MAXV[PEND_W-1:0];
      else                 pending <= sum[PEND_W-1:0];
    end
  end
endmodule

module score_arbiter #(
  parameter int                    NUM_SRC = 4,
  parameter int                    PEND_W  = 6,
  parameter logic [NUM_SRC*8-1:0]  POINTS  = {8'd25, 8'd10, 8'd5, 8'd1},
  parameter int                    PULSE_W = 2,
  parameter int                    GAP_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] hit,
  input  logic               enable,
  input  logic               clear,
  output logic               score,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output logic               sat_err
);
  localparam int PW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t                           state, state_nx;
  logic [CW-1:0]                    cnt, cnt_nx;
  logic [PW-1:0]                    ptr, ptr_nx, gidx;
  logic                             score_nx, found, do_grant;
  logic [NUM_SRC-1:0]               grant_nx, sel, nz, dec, satv;
  logic [NUM_SRC-1:0][PEND_W-1:0]   pending;
  int                               idx;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    score_arbiter_lane #(.PEND_W(PEND_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .hit     (hit[i]),
      .enable  (enable),
      .clear   (clear),
      .points  (POINTS[8*i +: 8]),
      .dec     (dec[i]),
      .pending (pending[i]),
      .sat     (satv[i])
    );
    assign nz[i] = |pending[i];
  end

  // circular search for the first non-empty source starting at ptr
  always_comb begin
    sel   = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && nz[idx]) begin
        found    = 1'b1;
        sel[idx] = 1'b1;
        gidx     = PW'(idx);
      end
    end
  end

  assign do_grant = (state == IDLE) & enable & found & ~clear;
  assign dec      = do_grant ? sel : '0;
  assign busy     = (|nz) | (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    score_nx = score;
    grant_nx = grant;
    ptr_nx   = ptr;
    if (clear) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      score_nx = 1'b0;
      grant_nx = '0;
    end else begin
      case (state)
        IDLE: if (do_grant) begin
          state_nx = PULSE;
          cnt_nx   = '0;
          score_nx = 1'b1;
          grant_nx = sel;
          ptr_nx   = (gidx == PW'(NUM_SRC - 1)) ? '0 : gidx + PW'(1);
        end
        PULSE: if (cnt == CW'(PULSE_W - 1)) begin
          state_nx = GAP;
          cnt_nx   = '0;
          score_nx = 1'b0;
          grant_nx = '0;
        end else cnt_nx = cnt + CW'(1);
        GAP: if (cnt == CW'(GAP_W - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else cnt_nx = cnt + CW'(1);
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      score   <= 1'b0;
      grant   <= '0;
      sat_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
      score <= score_nx;
      grant <= grant_nx;
      if (clear)      sat_err <= 1'b0;
      else if (|satv) sat_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter: pulse counts, grant order, pacing, saturation,
// enable gating, clear and asynchronous reset.

module tb_score_arbiter;
  logic       clk = 1'b0;
  logic       rst, enable, clear, score, busy, sat_err;
  logic [3:0] hit, grant;

  always #5 clk = ~clk;

  score_arbiter dut (
    .clk(clk), .rst(rst), .hit(hit), .enable(enable), .clear(clear),
    .score(score), .grant(grant), .busy(busy), .sat_err(sat_err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pulse monitor: logs grant and cycle at each sampled rising edge of score
  int         cyc = 0, npulse = 0, nhigh = 0, nbad = 0;
  logic       sprev = 1'b0;
  logic [3:0] glog [0:1023];
  int         tlog [0:1023];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (score === 1'b1 && sprev !== 1'b1 && npulse < 1024) begin
      glog[npulse] = grant;
      tlog[npulse] = cyc;
      npulse++;
    end
    if (score === 1'b1) nhigh++;
    if ((score === 1'b1) ? ($countones(grant) != 1) : (grant !== 4'b0)) nbad++;
    sprev = score;
  end

  function automatic int count_g(input int b, input int e, input logic [3:0] g);
    int c = 0;
    for (int k = b; k < e; k++) if (glog[k] == g) c++;
    return c;
  endfunction

  function automatic int bad_period(input int b, input int e);
    int c = 0;
    for (int k = b + 1; k < e; k++) if (tlog[k] - tlog[k-1] != 5) c++;
    return c;
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; hit = '0; enable = 1'b1; clear = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k = 0;
    while (busy !== 1'b0 && k < maxc) begin
      step(1);
      k++;
    end
    check({tag, "_idle"}, busy, 0);
    step(10);
  endtask

  task automatic wait_pulses(input string tag, input int target, input int maxc);
    int k = 0;
    while (npulse < target && k < maxc) begin
      step(1);
      k++;
    end
    check({tag, "_reached"}, (npulse >= target), 1);
  endtask

  int b, h0;

  initial begin
    rst = 1'b1; hit = '0; enable = 1'b1; clear = 1'b0;
    step(2);
    check("rst_score", score, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_sat", sat_err, 0);
    rst = 1'b0;
    step(1);

    // single 5-point hit on source 1
    b = npulse; h0 = nhigh;
    hit = 4'b0010; step(1);
    check("t1_lat_lo", score, 0);
    check("t1_busy", busy, 1);
    step(1);
    check("t1_lat_hi", score, 1);
    check("t1_grant", grant, 4'b0010);
    hit = '0;
    wait_idle("t1", 100);
    check("t1_count", npulse - b, 5);
    check("t1_src1", count_g(b, npulse, 4'b0010), 5);
    check("t1_width", nhigh - h0, 10);
    check("t1_period", bad_period(b, npulse), 0);

    // sources 0 and 3 together: 0 then 3 repeatedly
    do_reset();
    b = npulse;
    hit = 4'b1001; step(1);
    hit = '0;
    wait_idle("t2", 400);
    check("t2_count", npulse - b, 26);
    check("t2_first", glog[b], 4'b0001);
    check("t2_second", glog[b+1], 4'b1000);
    check("t2_src0", count_g(b, npulse, 4'b0001), 1);
    check("t2_last", glog[b+25], 4'b1000);

    // source 3 hit three times while the first point of source 0 is in flight
    do_reset();
    b = npulse;
    hit = 4'b0001; step(1);
    hit = 4'b1000; step(1);
    hit = 4'b0000; step(1);
    hit = 4'b1000; step(1);
    hit = 4'b0000; step(1);
    hit = 4'b1000; step(1);
    hit = 4'b0000;
    check("t3_sat_set", sat_err, 1);
    wait_idle("t3", 600);
    check("t3_count", npulse - b, 64);
    check("t3_src3", count_g(b, npulse, 4'b1000), 63);
    check("t3_sat_sticky", sat_err, 1);
    clear = 1'b1; step(1); clear = 1'b0;
    check("t3_sat_clr", sat_err, 0);

    // enable dropped after the third of ten pulses
    do_reset();
    b = npulse; h0 = nhigh;
    hit = 4'b0100; step(1);
    hit = '0;
    wait_pulses("t4_p3", b + 3, 50);
    enable = 1'b0;
    hit = 4'b0010; step(2);
    hit = '0; step(20);
    check("t4_held", npulse - b, 3);
    check("t4_width", nhigh - h0, 6);
    check("t4_busy", busy, 1);
    enable = 1'b1;
    wait_idle("t4", 100);
    check("t4_count", npulse - b, 10);
    check("t4_src1", count_g(b, npulse, 4'b0010), 0);

    // clear while in the gap after the second pulse
    do_reset();
    b = npulse;
    hit = 4'b0100; step(1);
    hit = '0;
    wait_pulses("t5_p2", b + 2, 50);
    for (int k = 0; k < 10 && score === 1'b1; k++) step(1);
    clear = 1'b1; step(1); clear = 1'b0;
    check("t5_score", score, 0);
    check("t5_busy", busy, 0);
    step(20);
    check("t5_count", npulse - b, 2);
    hit = 4'b0001; step(1);
    hit = '0;
    wait_idle("t5", 50);
    check("t5_after", npulse - b, 3);
    check("t5_grant", glog[b+2], 4'b0001);

    // asynchronous reset mid-pulse, hit held high across release
    do_reset();
    b = npulse;
    hit = 4'b1000; step(2);
    check("t6_hi", score, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_score", score, 0);
    check("t6_grant", grant, 0);
    check("t6_busy", busy, 0);
    step(2);
    rst = 1'b0;
    step(20);
    check("t6_nopulse", npulse - b, 1);
    check("t6_idle", busy, 0);
    hit = '0; step(1);
    hit = 4'b1000; step(1);
    check("t6_rehit", busy, 1);
    hit = '0;
    wait_idle("t6", 200);
    check("t6_count", npulse - b, 26);

    check("grant_onehot", nbad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
